// File: rtl/udm_uart_pkg.sv
// ----------------------------------------------------------------------------
// udm_uart_pkg
//   Shared definitions for the UDM debug-path UART (TX now, RX later).
//   Contents:
//     uart_tx_state_e  frame state machine encoding
//     PAR_*            mode_i encodings for the parity setting
//     DIV_MIN          smallest usable bit period in clock cycles
//     has_parity()     true when a mode inserts a parity bit
//     parity_bit()     parity value for a data byte under a given mode
// ----------------------------------------------------------------------------
package udm_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DIV_MIN = 4;

    // Mode 11 is treated like 00 so a stray config never inserts a bit.
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Even parity makes the total count of ones even, odd makes it odd.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/udm_sync_fifo.sv
// ----------------------------------------------------------------------------
// udm_sync_fifo
//   Single-clock FIFO with asynchronous active-low reset.
//   Ports:
//     clk_i    clock
//     rstn_i   asynchronous reset, active low (empties the FIFO)
//     push_i   write data_i this cycle (ignored when full unless popping too)
//     data_i   write data
//     pop_i    discard head entry this cycle (ignored when empty)
//     data_o   head entry (valid when !empty_o)
//     full_o   DEPTH entries held
//     empty_o  no entries held
// ----------------------------------------------------------------------------
module udm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // The count is one bit wider than the pointers so full and empty are
    // distinguishable; pointers wrap naturally because DEPTH is a power of two.
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot being written, so push is safe when full.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr];

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/udm_uart_tx.sv
// ----------------------------------------------------------------------------
// udm_uart_tx
//   UART transmitter for the UDM debug return path. Bytes arrive on a
//   valid/ready stream, queue in a small FIFO and leave as frames:
//   start, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
//   Ports:
//     clk_i       system clock
//     rstn_i      asynchronous reset, active low
//     div_i       bit period in clk_i cycles (clamped to at least DIV_MIN)
//     mode_i      parity: 00 none, 01 even, 10 odd, 11 none
//     in_valid_i  byte offered
//     in_data_i   byte to send
//     in_ready_o  FIFO can accept a byte this cycle
//     tx_o        serial line, idle high, registered
//     busy_o      frame in progress or bytes queued
// ----------------------------------------------------------------------------
module udm_uart_tx
    import udm_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [1:0]       mode_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             tx_o,
    output logic             busy_o
);

    uart_tx_state_e   state;
    uart_tx_state_e   state_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             push;
    logic             pop;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] frame_div;
    logic [DIV_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             par_q;
    logic             par_en_q;
    logic             stop_cnt;
    logic             bit_done;
    logic             last_stop;
    logic             tx_next;
    logic             tx_q;

    // Ready is held low during reset so nothing is accepted into a FIFO
    // that is being cleared.
    assign in_ready_o = rstn_i & ~fifo_full;
    assign push       = in_valid_i & in_ready_o;

    udm_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .data_i  (in_data_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Very short periods leave no room for the pop/latch pipeline, so the
    // divider never drops below DIV_MIN.
    assign div_eff   = (div_i < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_i;
    assign bit_done  = (timer == '0);
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign busy_o    = (state != ST_IDLE) | ~fifo_empty;
    assign tx_o      = tx_q;

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, FIFO pop and line level. The line level follows the
    // current state and is registered below, which gives the two-cycle
    // accept-to-start latency and keeps tx_o free of input paths.
    // Popping on the last stop cycle chains frames with no idle gap.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_next = shift_q[0];
                if (bit_done && bit_idx == 3'd7) begin
                    state_next = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_next = par_q;
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done && last_stop) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath. Divider and parity mode are captured at pop time so a
    // config change only affects frames that have not started yet.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_div <= DIV_W'(DIV_MIN);
            timer     <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            stop_cnt  <= 1'b0;
        end else if (pop) begin
            frame_div <= div_eff;
            timer     <= div_eff - DIV_W'(1);
            bit_idx   <= '0;
            shift_q   <= fifo_data;
            par_q     <= parity_bit(fifo_data, mode_i);
            par_en_q  <= has_parity(mode_i);
            stop_cnt  <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (bit_done) begin
                timer <= frame_div - DIV_W'(1);
                if (state == ST_DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
                if (state == ST_STOP) begin
                    stop_cnt <= stop_cnt + 1'b1;
                end
            end else begin
                timer <= timer - DIV_W'(1);
            end
        end
    end

    // Line flop; reset forces the line high at once, aborting any frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= tx_next;
        end
    end

endmodule

// File: tb/tb_udm_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_udm_uart_tx
//   Directed bench for udm_uart_tx. One instance uses one stop bit, a
//   second uses two stop bits for the 115200-baud frame. A small receiver
//   task samples each bit in its middle and reports the start-bit cycle so
//   frame lengths and back-to-back spacing can be compared exactly.
// ----------------------------------------------------------------------------
module tb_udm_uart_tx;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b1;
    logic [31:0] div_i = 32'd16;
    logic [1:0]  mode_i = 2'b00;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_ready_o;
    logic        tx_o;
    logic        busy_o;

    logic        in_valid2 = 1'b0;
    logic [7:0]  in_data2 = 8'h00;
    logic        in_ready2;
    logic        tx2;
    logic        busy2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    udm_uart_tx #(.FIFO_DEPTH(8), .STOP_BITS(1), .DIV_W(32)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .div_i      (div_i),
        .mode_i     (mode_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .tx_o       (tx_o),
        .busy_o     (busy_o)
    );

    udm_uart_tx #(.FIFO_DEPTH(8), .STOP_BITS(2), .DIV_W(32)) dut2 (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .div_i      (div_i),
        .mode_i     (mode_i),
        .in_valid_i (in_valid2),
        .in_data_i  (in_data2),
        .in_ready_o (in_ready2),
        .tx_o       (tx2),
        .busy_o     (busy2)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Free-running edge counter used to time-stamp start bits.
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic logic lineOf(input int which);
        return (which != 0) ? tx2 : tx_o;
    endfunction

    function automatic logic busyOf(input int which);
        return (which != 0) ? busy2 : busy_o;
    endfunction

    function automatic logic readyOf(input int which);
        return (which != 0) ? in_ready2 : in_ready_o;
    endfunction

    // Offer one byte and hold it until it is accepted. Ready only changes at
    // clock edges, so sampling it between edges predicts the transfer.
    task automatic applyStimulus(input int which, input logic [7:0] b);
        int waited;
        waited = 0;
        if (which != 0) begin in_valid2 = 1'b1; in_data2 = b; end
        else begin in_valid_i = 1'b1; in_data_i = b; end
        while (!readyOf(which) && waited < 20000) begin
            tick(1);
            waited++;
        end
        checkOutput("push_ready", {31'd0, readyOf(which)}, 32'd1);
        tick(1);
        if (which != 0) in_valid2 = 1'b0;
        else in_valid_i = 1'b0;
    endtask

    // Receive one frame: wait for the falling start edge, then sample every
    // bit at its middle. start_cyc is the clock edge at which the line fell.
    task automatic recvFrame(input int which, input int div, input bit par_en, input int stops,
                             output logic [7:0] data, output logic par, output logic frame_ok,
                             output int start_cyc, output logic timed_out);
        timed_out = 1'b1;
        data      = 8'h00;
        par       = 1'b0;
        frame_ok  = 1'b1;
        start_cyc = 0;
        for (int i = 0; i < 50000; i++) begin
            @(negedge clk);
            if (lineOf(which) == 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) return;
        start_cyc = cyc;
        repeat (div / 2) @(negedge clk);
        if (lineOf(which) != 1'b0) frame_ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
            repeat (div) @(negedge clk);
            data[b] = lineOf(which);
        end
        if (par_en) begin
            repeat (div) @(negedge clk);
            par = lineOf(which);
        end
        for (int s = 0; s < stops; s++) begin
            repeat (div) @(negedge clk);
            if (lineOf(which) != 1'b1) frame_ok = 1'b0;
        end
    endtask

    task automatic waitIdle(input int which, input string tag);
        for (int i = 0; i < 30000; i++) begin
            if (!busyOf(which)) break;
            tick(1);
        end
        checkOutput(tag, {31'd0, busyOf(which)}, 32'd0);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rx_data;
        logic       rx_par;
        logic       rx_ok;
        logic       rx_to;
        int         st;
        int         st_prev;
        int         st1;
        logic [9:0] exp_a5;
        logic [1:0] exp_par;
        logic       stayed_high;

        // ---------------- power-on reset ----------------
        #3 rstn_i = 1'b0;
        #2;
        checkOutput("rst_tx", {31'd0, tx_o}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_ready", {31'd0, in_ready_o}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstn_i = 1'b1;
        tick(1);
        checkOutput("rel_ready", {31'd0, in_ready_o}, 32'd1);
        checkOutput("rel_tx", {31'd0, tx_o}, 32'd1);

        // ---------------- T2: single byte A5, no parity ----------------
        $display("[TB] T2 single byte");
        div_i  = 32'd16;
        mode_i = 2'b00;
        exp_a5 = 10'b11_0100_1010;
        applyStimulus(0, 8'hA5);                   // accepted at edge N
        tick(1);                                   // N+1
        checkOutput("t2_tx_n1", {31'd0, tx_o}, 32'd1);
        checkOutput("t2_busy_n1", {31'd0, busy_o}, 32'd1);
        tick(1);                                   // N+2: start bit
        checkOutput("t2_tx_n2", {31'd0, tx_o}, 32'd0);
        tick(8);
        checkOutput("t2_bit0", {31'd0, tx_o}, {31'd0, exp_a5[0]});
        for (int i = 1; i < 10; i++) begin
            tick(16);
            checkOutput($sformatf("t2_bit%0d", i), {31'd0, tx_o}, {31'd0, exp_a5[i]});
        end
        tick(6);                                   // N+160
        checkOutput("t2_busy_n160", {31'd0, busy_o}, 32'd1);
        tick(2);                                   // N+162
        checkOutput("t2_busy_n162", {31'd0, busy_o}, 32'd0);
        checkOutput("t2_idle_tx", {31'd0, tx_o}, 32'd1);

        // ---------------- T3: parity ----------------
        $display("[TB] T3 parity");
        exp_par = 2'b10;                           // even -> 0, odd -> 1
        for (int m = 1; m <= 2; m++) begin
            mode_i = 2'(m);
            applyStimulus(0, 8'h03);
            recvFrame(0, 16, 1'b1, 1, rx_data, rx_par, rx_ok, st, rx_to);
            checkOutput($sformatf("t3_timeout_m%0d", m), {31'd0, rx_to}, 32'd0);
            checkOutput($sformatf("t3_data_m%0d", m), {24'd0, rx_data}, 32'h03);
            checkOutput($sformatf("t3_par_m%0d", m), {31'd0, rx_par}, {31'd0, exp_par[m-1]});
            checkOutput($sformatf("t3_frame_m%0d", m), {31'd0, rx_ok}, 32'd1);
            waitUntil(st + 174);
            checkOutput($sformatf("t3_busy175_m%0d", m), {31'd0, busy_o}, 32'd1);
            waitUntil(st + 175);
            checkOutput($sformatf("t3_busy176_m%0d", m), {31'd0, busy_o}, 32'd0);
        end
        mode_i = 2'b00;
        tick(1);

        // ---------------- T4: back-to-back, FIFO full ----------------
        $display("[TB] T4 back-to-back");
        fork
            begin
                for (int i = 0; i < 9; i++) applyStimulus(0, 8'(i));
                checkOutput("t4_full_ready", {31'd0, in_ready_o}, 32'd0);
            end
            begin
                st_prev = 0;
                for (int i = 0; i < 9; i++) begin
                    recvFrame(0, 16, 1'b0, 1, rx_data, rx_par, rx_ok, st, rx_to);
                    checkOutput($sformatf("t4_timeout%0d", i), {31'd0, rx_to}, 32'd0);
                    checkOutput($sformatf("t4_data%0d", i), {24'd0, rx_data}, i);
                    checkOutput($sformatf("t4_frame%0d", i), {31'd0, rx_ok}, 32'd1);
                    if (i > 0) checkOutput($sformatf("t4_gap%0d", i), st - st_prev, 32'd160);
                    st_prev = st;
                end
            end
        join
        waitIdle(0, "t4_idle");
        checkOutput("t4_ready_back", {31'd0, in_ready_o}, 32'd1);

        // ---------------- T5: clamp and config latch ----------------
        $display("[TB] T5 clamp and latch");
        div_i = 32'd2;
        tick(1);
        applyStimulus(0, 8'h5A);
        recvFrame(0, 4, 1'b0, 1, rx_data, rx_par, rx_ok, st, rx_to);
        checkOutput("t5_timeout", {31'd0, rx_to}, 32'd0);
        checkOutput("t5_data", {24'd0, rx_data}, 32'h5A);
        checkOutput("t5_frame", {31'd0, rx_ok}, 32'd1);
        waitUntil(st + 38);
        checkOutput("t5_busy39", {31'd0, busy_o}, 32'd1);
        waitUntil(st + 39);
        checkOutput("t5_busy40", {31'd0, busy_o}, 32'd0);

        div_i = 32'd868;
        tick(1);
        applyStimulus(0, 8'h3C);
        applyStimulus(0, 8'hC3);
        fork
            begin
                recvFrame(0, 868, 1'b0, 1, rx_data, rx_par, rx_ok, st1, rx_to);
                checkOutput("t5_f1_timeout", {31'd0, rx_to}, 32'd0);
                checkOutput("t5_f1_data", {24'd0, rx_data}, 32'h3C);
                checkOutput("t5_f1_frame", {31'd0, rx_ok}, 32'd1);
                recvFrame(0, 16, 1'b0, 1, rx_data, rx_par, rx_ok, st, rx_to);
                checkOutput("t5_f2_timeout", {31'd0, rx_to}, 32'd0);
                checkOutput("t5_f2_data", {24'd0, rx_data}, 32'hC3);
                checkOutput("t5_f2_frame", {31'd0, rx_ok}, 32'd1);
                checkOutput("t5_f1_len", st - st1, 32'd8680);
            end
            begin
                tick(200);
                div_i = 32'd16;
            end
        join
        waitIdle(0, "t5_idle");

        // ---------------- T1: reset mid-frame ----------------
        $display("[TB] T1 reset mid-frame");
        div_i = 32'd16;
        tick(1);
        applyStimulus(0, 8'h81);
        applyStimulus(0, 8'h42);
        tick(3);
        checkOutput("t1_in_start", {31'd0, tx_o}, 32'd0);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("t1_rst_tx", {31'd0, tx_o}, 32'd1);
        checkOutput("t1_rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("t1_rst_ready", {31'd0, in_ready_o}, 32'd0);
        tick(2);
        @(negedge clk) rstn_i = 1'b1;
        tick(1);
        stayed_high = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (tx_o != 1'b1 || busy_o != 1'b0) stayed_high = 1'b0;
            tick(1);
        end
        checkOutput("t1_quiet_after", {31'd0, stayed_high}, 32'd1);
        applyStimulus(0, 8'h96);
        recvFrame(0, 16, 1'b0, 1, rx_data, rx_par, rx_ok, st, rx_to);
        checkOutput("t1_timeout", {31'd0, rx_to}, 32'd0);
        checkOutput("t1_data", {24'd0, rx_data}, 32'h96);
        checkOutput("t1_frame", {31'd0, rx_ok}, 32'd1);
        waitIdle(0, "t1_idle");

        // ---------------- T6: 115200 baud, two stop bits ----------------
        $display("[TB] T6 115200 baud");
        div_i  = 32'd868;
        mode_i = 2'b00;
        tick(1);
        applyStimulus(1, 8'hCC);
        recvFrame(1, 868, 1'b0, 2, rx_data, rx_par, rx_ok, st, rx_to);
        checkOutput("t6_timeout", {31'd0, rx_to}, 32'd0);
        checkOutput("t6_data", {24'd0, rx_data}, 32'hCC);
        checkOutput("t6_frame", {31'd0, rx_ok}, 32'd1);
        waitUntil(st + 9546);
        checkOutput("t6_busy_end", {31'd0, busy2}, 32'd1);
        waitUntil(st + 9547);
        checkOutput("t6_busy_done", {31'd0, busy2}, 32'd0);
        checkOutput("t6_tx_idle", {31'd0, tx2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
